// File: rtl/alu_ctrl_mdu_if.sv
// alu_ctrl_mdu_if
//   Execute-stage bundle between the core and alu_ctrl_mdu.
//   master (core): drives valid_in, opcode, rtype_fncode, op_a, op_b;
//                  receives fncode, stall, busy, hi_out, lo_out.
//   slave  (alu_ctrl_mdu): the mirror image of master.
interface alu_ctrl_mdu_if #(
  parameter int WIDTH = 32,
  parameter int FN_W  = 6
) ();
  logic             valid_in;
  logic [FN_W-1:0]  opcode;
  logic [FN_W-1:0]  rtype_fncode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [FN_W-1:0]  fncode;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output valid_in, opcode, rtype_fncode, op_a, op_b,
    input  fncode, stall, busy, hi_out, lo_out
  );

  modport slave (
    input  valid_in, opcode, rtype_fncode, op_a, op_b,
    output fncode, stall, busy, hi_out, lo_out
  );
endinterface

// File: rtl/alu_ctrl_mdu.sv
// alu_ctrl_mdu
//   ALU function decoder plus HI/LO registers and an iterative multiply/divide
//   sequencer (MULT/MULTU/DIV/DIVU, one result bit per clock).
//   Ports:
//     clk    - clock, all state on the rising edge
//     reset  - synchronous, active-high; clears HI/LO and aborts a running op
//     bus    - alu_ctrl_mdu_if.slave: valid_in/opcode/rtype_fncode/op_a/op_b in;
//              fncode (combinational), stall, busy, hi_out, lo_out out
//   Build option:
//     MDU_FAST_MULT_EN - multiplies complete in one cycle (HI/LO written at the
//                        accept edge, busy never set); divides stay iterative.
module alu_ctrl_mdu #(
  parameter int WIDTH = 32,
  parameter int FN_W  = 6
) (
  input logic           clk,
  input logic           reset,
  alu_ctrl_mdu_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [FN_W-1:0] OP_RTYPE = FN_W'(6'h00);
  localparam logic [FN_W-1:0] OP_ADDIU = FN_W'(6'h09);
  localparam logic [FN_W-1:0] OP_SLTI  = FN_W'(6'h0A);
  localparam logic [FN_W-1:0] OP_SLTIU = FN_W'(6'h0B);
  localparam logic [FN_W-1:0] OP_ANDI  = FN_W'(6'h0C);
  localparam logic [FN_W-1:0] OP_ORI   = FN_W'(6'h0D);
  localparam logic [FN_W-1:0] OP_XORI  = FN_W'(6'h0E);
  localparam logic [FN_W-1:0] OP_LB    = FN_W'(6'h20);
  localparam logic [FN_W-1:0] OP_LH    = FN_W'(6'h21);
  localparam logic [FN_W-1:0] OP_LWL   = FN_W'(6'h22);
  localparam logic [FN_W-1:0] OP_LW    = FN_W'(6'h23);
  localparam logic [FN_W-1:0] OP_LBU   = FN_W'(6'h24);
  localparam logic [FN_W-1:0] OP_LHU   = FN_W'(6'h25);
  localparam logic [FN_W-1:0] OP_LWR   = FN_W'(6'h26);
  localparam logic [FN_W-1:0] OP_SW    = FN_W'(6'h2B);

  localparam logic [FN_W-1:0] F_MFHI  = FN_W'(6'h10);
  localparam logic [FN_W-1:0] F_MTHI  = FN_W'(6'h11);
  localparam logic [FN_W-1:0] F_MFLO  = FN_W'(6'h12);
  localparam logic [FN_W-1:0] F_MTLO  = FN_W'(6'h13);
  localparam logic [FN_W-1:0] F_MULT  = FN_W'(6'h18);
  localparam logic [FN_W-1:0] F_MULTU = FN_W'(6'h19);
  localparam logic [FN_W-1:0] F_DIV   = FN_W'(6'h1A);
  localparam logic [FN_W-1:0] F_DIVU  = FN_W'(6'h1B);
  localparam logic [FN_W-1:0] F_ADDU  = FN_W'(6'h21);
  localparam logic [FN_W-1:0] F_AND   = FN_W'(6'h24);
  localparam logic [FN_W-1:0] F_OR    = FN_W'(6'h25);
  localparam logic [FN_W-1:0] F_XOR   = FN_W'(6'h26);
  localparam logic [FN_W-1:0] F_SLT   = FN_W'(6'h2A);
  localparam logic [FN_W-1:0] F_SLTU  = FN_W'(6'h2B);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo;
  // acc_hi/acc_lo: partial product (multiply) or remainder/quotient (divide)
  logic [WIDTH-1:0] acc_hi, acc_lo, divisor;
  logic             run_mul, neg_lo, neg_hi;

  logic [FN_W-1:0]  funct;
  logic [FN_W-1:0]  fncode_c;
  logic             busy, is_rtype, is_mdu, is_mul, is_div, is_sgn;
  logic             accept, start, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   sum, shifted;
  logic             ge;
  logic [WIDTH-1:0] diff, step_hi, step_lo, res_hi, res_lo;
  logic [2*WIDTH-1:0] prod;

  assign funct = bus.rtype_fncode;

  always_comb begin
    fncode_c = '1;
    case (bus.opcode)
      OP_RTYPE: fncode_c = bus.rtype_fncode;
      OP_ADDIU, OP_SW, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LWL, OP_LWR:
                fncode_c = F_ADDU;
      OP_ANDI:  fncode_c = F_AND;
      OP_ORI:   fncode_c = F_OR;
      OP_XORI:  fncode_c = F_XOR;
      OP_SLTI:  fncode_c = F_SLT;
      OP_SLTIU: fncode_c = F_SLTU;
      default:  fncode_c = '1;
    endcase
  end

  assign busy     = (state == ST_RUN);
  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign is_mdu   = is_rtype && (funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU,
                                                F_MFHI, F_MFLO, F_MTHI, F_MTLO});
  assign is_mul   = is_rtype && (funct == F_MULT || funct == F_MULTU);
  assign is_div   = is_rtype && (funct == F_DIV || funct == F_DIVU);
  assign is_sgn   = (funct == F_MULT || funct == F_DIV);
  assign accept   = bus.valid_in & is_mdu & ~busy;

  assign a_neg = is_sgn & bus.op_a[WIDTH-1];
  assign b_neg = is_sgn & bus.op_b[WIDTH-1];
  assign mag_a = a_neg ? -bus.op_a : bus.op_a;
  assign mag_b = b_neg ? -bus.op_b : bus.op_b;

`ifdef MDU_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod;
  // Sign-extending to 2*WIDTH makes the truncated unsigned product the signed one.
  assign fast_prod = {{WIDTH{a_neg}}, bus.op_a} * {{WIDTH{b_neg}}, bus.op_b};
  assign start = accept & is_div & (bus.op_b != '0);
`else
  assign start = accept & (is_mul | (is_div & (bus.op_b != '0)));
`endif

  // One iteration: shift-add multiply or restoring divide, sharing acc/divisor.
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    // Remainder stays below divisor, so the low WIDTH bits suffice.
    diff    = shifted[WIDTH-1:0] - divisor;
    if (run_mul) begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      step_hi = ge ? diff : shifted[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], ge};
    end
    prod = neg_lo ? -{step_hi, step_lo} : {step_hi, step_lo};
    if (run_mul) begin
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      res_lo = neg_lo ? -step_lo : step_lo;
      res_hi = neg_hi ? -step_hi : step_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      divisor <= '0;
      run_mul <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
    end else if (state == ST_RUN) begin
      acc_hi <= step_hi;
      acc_lo <= step_lo;
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) begin
        state <= ST_IDLE;
        hi    <= res_hi;
        lo    <= res_lo;
      end
    end else if (start) begin
      state   <= ST_RUN;
      cnt     <= '0;
      acc_hi  <= '0;
      acc_lo  <= mag_a;
      divisor <= mag_b;
      run_mul <= is_mul;
      neg_lo  <= a_neg ^ b_neg;
      // Product sign covers both halves; remainder follows the dividend.
      neg_hi  <= is_mul ? (a_neg ^ b_neg) : a_neg;
    end else if (accept) begin
`ifdef MDU_FAST_MULT_EN
      if (is_mul) begin
        hi <= fast_prod[2*WIDTH-1:WIDTH];
        lo <= fast_prod[WIDTH-1:0];
      end
`endif
      if (funct == F_MTHI) hi <= bus.op_a;
      if (funct == F_MTLO) lo <= bus.op_a;
    end
  end

  assign bus.fncode = fncode_c;
  assign bus.stall  = bus.valid_in & is_mdu & busy;
  assign bus.busy   = busy;
  assign bus.hi_out = hi;
  assign bus.lo_out = lo;
endmodule

// File: tb/tb_alu_ctrl_mdu.sv
module tb_alu_ctrl_mdu;
  localparam int W = 32;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;
  logic [5:0] exp_fn [64];
  logic [5:0] start_ops [8];

  alu_ctrl_mdu_if #(.WIDTH(W), .FN_W(6)) bus ();
  alu_ctrl_mdu #(.WIDTH(W), .FN_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Architectural result {HI,LO} of an MDU op, from plain 64-bit arithmetic.
  function automatic logic [63:0] mdu_model(input logic [5:0] f, input logic [31:0] a,
                                            input logic [31:0] b, input logic [63:0] prev);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    res = prev;
    case (f)
      F_MULT:  res = 64'(sa * sb);
      F_MULTU: res = {32'b0, a} * {32'b0, b};
      F_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; res = {r[31:0], q[31:0]}; end
      F_DIVU:  if (b != 0) res = {a % b, a / b};
      F_MTHI:  res = {a, prev[31:0]};
      F_MTLO:  res = {prev[63:32], a};
      default: res = prev;
    endcase
    return res;
  endfunction

  function automatic int busy_cycles(input logic [5:0] f, input logic [31:0] b);
    if (f == F_DIV || f == F_DIVU) return (b != 0) ? 32 : 0;
`ifdef MDU_FAST_MULT_EN
    if (f == F_MULT || f == F_MULTU) return 0;
`else
    if (f == F_MULT || f == F_MULTU) return 32;
`endif
    return 0;
  endfunction

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    bus.valid_in = 1'b1;
    bus.opcode = 6'h00;
    bus.rtype_fncode = f;
    bus.op_a = a;
    bus.op_b = b;
    #1;
  endtask

  // Issue one MDU op, keep a non-MDU instruction flowing while busy, check result.
  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    logic [63:0] exp;
    drive(f, a, b);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin tick; n++; end
    check({tag, "_accept"}, 64'(n < 100), 64'd1);
    if (f == F_MFHI) check({tag, "_mfhi"}, bus.hi_out, hi_m);
    if (f == F_MFLO) check({tag, "_mflo"}, bus.lo_out, lo_m);
    exp = mdu_model(f, a, b, {hi_m, lo_m});
    tick;
    bus.opcode = OP_ADDIU;
    bus.rtype_fncode = 6'($urandom);
    bus.op_a = $urandom;
    bus.op_b = $urandom;
    #1;
    check({tag, "_nonmdu_stall"}, bus.stall, 0);
    check({tag, "_nonmdu_fn"}, bus.fncode, 6'h21);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin tick; n++; end
    bus.valid_in = 1'b0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(busy_cycles(f, b)));
    check({tag, "_hi"}, bus.hi_out, exp[63:32]);
    check({tag, "_lo"}, bus.lo_out, exp[31:0]);
    hi_m = exp[63:32];
    lo_m = exp[31:0];
  endtask

  initial begin
    int n;
    logic [5:0] f;
    logic [31:0] a, b;

    for (int i = 0; i < 64; i++) exp_fn[i] = 6'h3F;
    foreach (exp_fn[i]) if (i inside {9, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2B})
      exp_fn[i] = 6'h21;
    exp_fn[6'h0C] = 6'h24;
    exp_fn[6'h0D] = 6'h25;
    exp_fn[6'h0E] = 6'h26;
    exp_fn[6'h0A] = 6'h2A;
    exp_fn[6'h0B] = 6'h2B;
    start_ops = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MTHI, F_MTLO, F_MFHI, F_MFLO};

    bus.valid_in = 1'b0;
    bus.opcode = 6'h00;
    bus.rtype_fncode = 6'h00;
    bus.op_a = '0;
    bus.op_b = '0;
    reset = 1'b1;
    repeat (3) tick;
    reset = 1'b0;
    check("reset_busy", bus.busy, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_hi", bus.hi_out, 0);
    check("reset_lo", bus.lo_out, 0);

    // Decoder: directed vectors, then every opcode with a random funct.
    bus.opcode = 6'h23; #1; check("dec_lw", bus.fncode, 6'h21);
    bus.opcode = 6'h0D; #1; check("dec_ori", bus.fncode, 6'h25);
    bus.opcode = 6'h00; bus.rtype_fncode = 6'h23; #1; check("dec_subu", bus.fncode, 6'h23);
    bus.opcode = 6'h3F; #1; check("dec_3f", bus.fncode, 6'h3F);
    for (int i = 0; i < 64; i++) begin
      bus.opcode = 6'(i);
      bus.rtype_fncode = 6'($urandom);
      #1;
      check("dec_sweep", bus.fncode, (i == 0) ? bus.rtype_fncode : exp_fn[i]);
    end
    tick;

    run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'd2);
    check("multu_max_hi_const", bus.hi_out, 32'h00000001);
    check("multu_max_lo_const", bus.lo_out, 32'hFFFFFFFE);

    // DIV -7/2 with MFLO arriving mid-run.
    drive(F_DIV, 32'hFFFFFFF9, 32'd2);
    tick;
    bus.valid_in = 1'b0;
    repeat (4) tick;
    drive(F_MFLO, 32'h0, 32'h0);
    check("div_mflo_stall", bus.stall, 1);
    n = 0;
    while (bus.stall === 1'b1 && n < 100) begin tick; n++; end
    check("div_mflo_stall_cycles", 64'(n), 64'd28);
    check("div_neg_lo", bus.lo_out, 32'hFFFFFFFD);
    check("div_neg_hi", bus.hi_out, 32'hFFFFFFFF);
    tick;
    bus.valid_in = 1'b0;
    hi_m = 32'hFFFFFFFF;
    lo_m = 32'hFFFFFFFD;

    run_op("divu_zero", F_DIVU, 32'd100, 32'd0);
    run_op("mthi", F_MTHI, 32'h1234, 32'h0);
    check("mthi_const", bus.hi_out, 32'h1234);

    // MULT aborted by reset.
    drive(F_MULT, 32'hFFFFFFFD, 32'd5);
    tick;
    bus.valid_in = 1'b0;
    repeat (9) tick;
`ifdef MDU_FAST_MULT_EN
    check("abort_busy_before", bus.busy, 0);
`else
    check("abort_busy_before", bus.busy, 1);
`endif
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_hi", bus.hi_out, 0);
    check("abort_lo", bus.lo_out, 0);
    hi_m = '0;
    lo_m = '0;
    run_op("mult_6x7", F_MULT, 32'd6, 32'd7);
    check("mult_6x7_const", bus.lo_out, 32'd42);

    // Most-negative / -1, then a DIVU presented on the completion cycle.
    drive(F_DIV, 32'h80000000, 32'hFFFFFFFF);
    tick;
    bus.valid_in = 1'b0;
    repeat (31) tick;
    check("ovf_busy_last", bus.busy, 1);
    drive(F_DIVU, 32'd1000, 32'd7);
    check("b2b_stall", bus.stall, 1);
    tick;
    check("b2b_stall_after", bus.stall, 0);
    check("ovf_lo", bus.lo_out, 32'h80000000);
    check("ovf_hi", bus.hi_out, 32'h0);
    tick;
    bus.valid_in = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin tick; n++; end
    check("b2b_busy_cycles", 64'(n), 64'd32);
    check("b2b_lo", bus.lo_out, 32'd142);
    check("b2b_hi", bus.hi_out, 32'd6);
    hi_m = 32'd6;
    lo_m = 32'd142;

    // Randomized mix against the arithmetic model.
    for (int i = 0; i < 24; i++) begin
      f = start_ops[$urandom_range(0, 7)];
      a = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op("rand", f, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
